// File: rtl/mpsoc_dbg_wb_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mpsoc_dbg_wb_burst_ctrl
// Purpose : Debug burst sequencer feeding the WishBone BIU one word at a time.
//           Optional CRC-32 over transferred words: MPSOC_DBG_BURST_CRC_EN.
// Revision: 1.0 - initial release
// ============================================================================
module mpsoc_dbg_wb_burst_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  biu_clk,
  input  logic                  biu_rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [3:0]            cmd_size,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err_sticky,
  output logic [ADDR_WIDTH-1:0] err_addr,
  input  logic                  err_clr,
`ifdef MPSOC_DBG_BURST_CRC_EN
  output logic [31:0]           crc,
`endif
  output logic                  biu_strb,
  output logic                  biu_rw,
  output logic [ADDR_WIDTH-1:0] biu_addr,
  output logic [DATA_WIDTH-1:0] biu_di,
  output logic [3:0]            biu_word_size,
  input  logic                  biu_rdy,
  input  logic [DATA_WIDTH-1:0] biu_do,
  input  logic                  biu_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_we;
  logic                  r_rw;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_size;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [DATA_WIDTH-1:0] r_di;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_err_sticky;
  logic [ADDR_WIDTH-1:0] r_err_addr;

  logic                  w_cmd_acc;
  logic                  w_wr_acc;
  logic                  w_biu_ret;
  logic                  w_err_cap;
  logic [3:0]            w_size_in;
  logic [DATA_WIDTH-1:0] w_di_nxt;

  assign cmd_ready     = (r_state == S_IDLE);
  assign wr_ready      = (r_state == S_FETCH);
  assign rd_valid      = (r_state == S_DRAIN);
  assign biu_strb      = (r_state == S_ISSUE);
  assign done          = (r_state == S_DONE);
  assign busy          = (r_state != S_IDLE) && (r_state != S_DONE);
  assign rd_data       = r_rd_data;
  assign err_sticky    = r_err_sticky;
  assign err_addr      = r_err_addr;
  assign biu_rw        = r_rw;
  assign biu_addr      = r_addr;
  assign biu_di        = r_di;
  assign biu_word_size = r_size;

  assign w_cmd_acc = cmd_valid && cmd_ready;
  assign w_wr_acc  = wr_valid && wr_ready;
  assign w_biu_ret = (r_state == S_WAIT) && biu_rdy;
  assign w_err_cap = w_biu_ret && biu_err && !r_err_sticky;

  // Unsupported word sizes fall back to full-word transfers.
  always_comb begin
    w_size_in = 4'd4;
    if ((cmd_size == 4'd1) || (cmd_size == 4'd2))
      w_size_in = cmd_size;
  end

  // The BIU expects write data MSB-justified within the bus word.
  always_comb begin
    w_di_nxt = wr_data;
    case (r_size)
      4'd1:    w_di_nxt = {wr_data[7:0],  {(DATA_WIDTH-8){1'b0}}};
      4'd2:    w_di_nxt = {wr_data[15:0], {(DATA_WIDTH-16){1'b0}}};
      default: w_di_nxt = wr_data;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_acc) begin
          if (cmd_count == '0) w_state_nxt = S_DONE;
          else if (cmd_we)     w_state_nxt = S_FETCH;
          else                 w_state_nxt = S_ISSUE;
        end
      end
      S_FETCH: if (wr_valid) w_state_nxt = S_ISSUE;
      S_ISSUE: if (biu_rdy)  w_state_nxt = S_WAIT;
      S_WAIT:  if (biu_rdy)  w_state_nxt = r_we ? S_NEXT : S_DRAIN;
      S_DRAIN: if (rd_ready) w_state_nxt = S_NEXT;
      S_NEXT: begin
        if (r_count == CNT_WIDTH'(1)) w_state_nxt = S_DONE;
        else                          w_state_nxt = r_we ? S_FETCH : S_ISSUE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge biu_clk or posedge biu_rst) begin
    if (biu_rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_size       <= '0;
      r_count      <= '0;
      r_di         <= '0;
      r_rd_data    <= '0;
      r_err_sticky <= 1'b0;
      r_err_addr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_acc) begin
        r_we    <= cmd_we;
        r_rw    <= ~cmd_we;
        r_addr  <= cmd_addr;
        r_size  <= w_size_in;
        r_count <= cmd_count;
      end
      if (w_wr_acc)
        r_di <= w_di_nxt;
      if (w_biu_ret && !r_we)
        r_rd_data <= biu_do;
      if (r_state == S_NEXT) begin
        r_addr  <= r_addr + ADDR_WIDTH'(r_size);
        r_count <= r_count - CNT_WIDTH'(1);
      end
      // Capture outranks a simultaneous clear so no error is ever lost.
      if (w_cmd_acc) begin
        r_err_sticky <= 1'b0;
        r_err_addr   <= '0;
      end else if (w_err_cap) begin
        r_err_sticky <= 1'b1;
        r_err_addr   <= r_addr;
      end else if (err_clr) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

`ifdef MPSOC_DBG_BURST_CRC_EN
  function automatic logic [31:0] crc32_word(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] v;
    v = c;
    for (int i = 0; i < 32; i++)
      v = (v[0] ^ d[i]) ? ((v >> 1) ^ 32'hEDB8_8320) : (v >> 1);
    return v;
  endfunction

  logic [31:0] r_crc;

  always_ff @(posedge biu_clk or posedge biu_rst) begin
    if (biu_rst)
      r_crc <= 32'hFFFF_FFFF;
    else if (w_cmd_acc)
      r_crc <= 32'hFFFF_FFFF;
    else if (w_wr_acc)
      r_crc <= crc32_word(r_crc, wr_data[31:0]);
    else if (w_biu_ret && !r_we)
      r_crc <= crc32_word(r_crc, biu_do[31:0]);
  end

  assign crc = r_crc;
`endif

endmodule
`default_nettype wire
